// File: rtl/mem_write_port.sv
// Buffers ALU memory writes in a small FIFO and commits them one at a time to a memory with variable ack latency.
// Optional feature: define MEM_WRITE_COALESCE_EN to merge a request into the newest entry when the addresses match.
module mem_write_port #(
  parameter int width          = 32,
  parameter int mem_addr_width = 16,
  parameter int depth          = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         w_valid_i,
  input  logic [mem_addr_width-1:0]    w_addr_i,
  input  logic [width-1:0]             w_write_i,
  output logic                         w_ready_o,
  output logic                         mem_en_o,
  output logic [mem_addr_width-1:0]    mem_addr_o,
  output logic [width-1:0]             mem_data_o,
  input  logic                         mem_ack_i,
  output logic [$clog2(depth+1)-1:0]   count_o,
  output logic                         idle_o
);

  localparam int pw = $clog2(depth);
  localparam int cw = $clog2(depth+1);
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                    state;
  logic [mem_addr_width-1:0] addr_mem [depth];
  logic [width-1:0]          data_mem [depth];
  logic [pw-1:0]             wr_ptr;
  logic [pw-1:0]             rd_ptr;
  logic [cw-1:0]             count;
  logic [cw-1:0]             count_nxt;
  logic                      accept;
  logic                      pop;
  logic                      push;
  logic                      merge;

  // Ready comes from registered count only; a pop in the same cycle does not free a slot early.
  assign w_ready_o = (count != full_cnt);
  assign accept    = w_valid_i && w_ready_o;
  assign pop       = (state == ISSUE) && mem_ack_i;

`ifdef MEM_WRITE_COALESCE_EN
  logic [pw-1:0] tail_ptr;
  assign tail_ptr = wr_ptr - 1'b1;
  // The head is locked once presented to memory, so a lone issuing entry is never merged into.
  assign merge = accept && (count != '0) && (addr_mem[tail_ptr] == w_addr_i) &&
                 !((state == ISSUE) && (count == cw'(1)));
`else
  assign merge = 1'b0;
`endif

  assign push = accept && !merge;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (pop && (count_nxt == '0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (push) begin
        addr_mem[wr_ptr] <= w_addr_i;
        data_mem[wr_ptr] <= w_write_i;
      end
`ifdef MEM_WRITE_COALESCE_EN
      if (merge) begin
        data_mem[tail_ptr] <= w_write_i;
      end
`endif
    end
  end

  assign mem_en_o   = (state == ISSUE);
  assign mem_addr_o = addr_mem[rd_ptr];
  assign mem_data_o = data_mem[rd_ptr];
  assign count_o    = count;
  assign idle_o     = (count == '0) && (state == IDLE);

endmodule

// File: doc/mem_write_port.md
# mem_write_port

Receiving end of the ALU memory-write interface. Accepts write requests (address + data) on a valid/ready handshake, buffers them in a small FIFO, and commits them one at a time to a downstream memory that acknowledges each write after a variable number of cycles. Sits between the ALU's write outputs and the memory/framebuffer so that ALU execution is decoupled from memory latency.

## Interface
Parameters:
- `width`, 32, data width of a write (matches register width).
- `mem_addr_width`, 16, memory address width.
- `depth`, 4, FIFO entries; power of two, >= 2.

Ports (one clock `clk_i`; reset `reset_i` is synchronous, active-high):
- `clk_i` in 1: clock; all state updates on rising edge.
- `reset_i` in 1: synchronous active-high reset.
- `w_valid_i` in 1: write request present.
- `w_addr_i` in `mem_addr_width`: write address.
- `w_write_i` in `width`: write data.
- `w_ready_o` out 1: port can accept a request this cycle.
- `mem_en_o` out 1: memory write request active.
- `mem_addr_o` out `mem_addr_width`: address of head entry.
- `mem_data_o` out `width`: data of head entry.
- `mem_ack_i` in 1: memory has committed the presented write.
- `count_o` out `$clog2(depth+1)`: entries currently buffered (includes the one being issued).
- `idle_o` out 1: no buffered or in-flight writes.

## Operation
- Transfer occurs on a cycle where `w_valid_i && w_ready_o`; entry pushed at FIFO tail.
- `w_ready_o = (count_o != depth)`; registered-state derived, no same-cycle pop bypass: when full, ready stays low even if a pop happens that cycle.
- States: `IDLE`, `ISSUE`.
  - `IDLE`: `mem_en_o = 0`. If `count_o != 0` -> `ISSUE` next cycle.
  - `ISSUE`: `mem_en_o = 1`, `mem_addr_o`/`mem_data_o` = head entry, held stable until ack. On `mem_ack_i`: pop head; if entries remain after the pop (including one pushed same cycle) stay in `ISSUE` and present new head next cycle, else -> `IDLE`.
- `mem_ack_i` while `mem_en_o = 0` is ignored.
- Simultaneous push and pop: `count_o` unchanged; both pointers advance.
- Pointers are `$clog2(depth)` bits and wrap modulo `depth`.
- `count_o` never exceeds `depth` and never underflows.
- `idle_o = (count_o == 0) && state == IDLE`.
- Writes are committed strictly in acceptance order.
- `mem_addr_o`/`mem_data_o` are don't-care while `mem_en_o = 0`.

## Timing
- Reset values: `w_ready_o = 1`, `mem_en_o = 0`, `count_o = 0`, `idle_o = 1`, state `IDLE`; FIFO contents undefined.
- Latency: request accepted at cycle N -> `mem_en_o` high at N+2 at the earliest (N+1 count update, N+2 `ISSUE`).
- Back-to-back: ack at cycle M with more entries pending -> next entry presented at M+1, `mem_en_o` stays high.
- Throughput: one write per cycle when memory acks every cycle.
- Reset mid-operation: all buffered and in-flight writes discarded; `mem_en_o = 0` the cycle after `reset_i` is sampled; a same-cycle `mem_ack_i` is ignored.

## Configuration
- `MEM_WRITE_COALESCE_EN` defined: a request whose `w_addr_i` equals the tail (newest) entry's address overwrites that entry's data instead of pushing, `count_o` unchanged. Coalescing never targets the head while in `ISSUE` (that entry is locked); in that case a normal push occurs. `w_ready_o` rule is unchanged.
- Not defined: every accepted request pushes a new entry; no address comparison logic.

## Test plan
- Single write: reset, push addr 0x0010 data 0xDEADBEEF, ack on first `mem_en_o` cycle -> `mem_en_o` high 2 cycles after push with that addr/data, `count_o` 1 -> 0, `idle_o` returns to 1.
- Fill and stall: hold `mem_ack_i = 0`, push 5 writes with `depth = 4` -> first 4 accepted, `w_ready_o` low at `count_o = 4`, 5th held until first ack, then accepted; commit order 1..5 preserved.
- Variable latency: ack after 0, 3, 1 wait cycles on three queued writes -> addr/data stable until each ack, each committed exactly once, `mem_en_o` continuous between them.
- Push/pop same cycle at count 2 -> `count_o` stays 2; wrap-around after 9 total writes yields correct order.
- Reset mid-operation: 3 entries queued, one issuing, assert `reset_i` with `mem_ack_i = 1` -> next cycle `mem_en_o = 0`, `count_o = 0`, no further commits.
- With `MEM_WRITE_COALESCE_EN`: ack held low, push (0x20, 1), (0x30, 2), (0x30, 3) -> `count_o = 2`, commits (0x20, 1) then (0x30, 3); without macro -> `count_o = 3`, three commits.
